// File: rtl/ntt_intt_ip_pkg.sv
// Shared definitions for the NTT/INTT IP sequencer.
// Op codes, sequencer state encoding and default sizing constants.
package ntt_intt_ip_pkg;

    localparam logic [5:0] NTT  = 6'h01;
    localparam logic [5:0] INTT = 6'h02;

    localparam int N_COEFF_DEF = 256;
    localparam int TIMEOUT_DEF = 65535;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        FILL,
        KICK,
        RUN,
        READ,
        DRAIN,
        DONE,
        ERR
    } seq_state_e;

    function automatic logic op_valid(input logic [5:0] op);
        return (op == NTT) || (op == INTT);
    endfunction

endpackage

// File: rtl/ntt_intt_out_buf.sv
// One-entry valid/ready skid register between core readout and consumer.
// Ports: push/push_data in, can_push out, out_valid/out_data/pop_ready, flush.
module ntt_intt_out_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic              can_push,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              full_q;
    logic [DATA_W-1:0] data_q;
    logic              pop;
    logic              load;

    // A pop in the same cycle frees the slot, so capture can overlap it.
    assign pop      = full_q & pop_ready;
    assign can_push = ~full_q | pop;
    assign load     = push & can_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (flush) begin
                full_q <= 1'b0;
            end else if (load) begin
                full_q <= 1'b1;
            end else if (pop) begin
                full_q <= 1'b0;
            end
            if (load && !flush) begin
                data_q <= push_data;
            end
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;

endmodule

// File: rtl/ntt_intt_ip_seq.sv
// Job sequencer driving the NTT/INTT core: load, fill, kick, run, read, drain.
// Ports: job control, input stream, core strobes/data, output stream, status.
module ntt_intt_ip_seq
    import ntt_intt_ip_pkg::*;
#(
    parameter int N_COEFF        = N_COEFF_DEF,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [5:0]                 operation_i,
    input  logic                       abort_i,
    input  logic                       in_valid_i,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       in_ready_o,
    output logic                       core_load_a_f_o,
    output logic                       core_load_a_i_o,
    output logic                       core_start_fntt_o,
    output logic                       core_start_intt_o,
    output logic                       core_read_a_o,
    output logic [DATA_W-1:0]          core_din_o,
    output logic                       core_din_en_o,
    input  logic                       core_done_i,
    input  logic [DATA_W-1:0]          core_dout_i,
    input  logic                       core_gnt_valid_i,
    output logic                       core_read_en_o,
    output logic                       out_valid_o,
    output logic [DATA_W-1:0]          out_data_o,
    input  logic                       out_ready_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [$clog2(N_COEFF):0]   cnt_o
);

    localparam int CW = $clog2(N_COEFF) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    seq_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [TW-1:0]     timer_q;
    logic              op_inv_q;
    logic              bad_op_q;
    logic [DATA_W-1:0] din_q;
    logic              din_en_q;

    logic busy;
    logic abort;
    logic go;
    logic accept;
    logic pop;
    logic last;
    logic buf_can_push;

    assign busy   = (state_q != IDLE);
    assign abort  = abort_i & busy;
    assign go     = (state_q == IDLE) & start_i & op_valid(operation_i);
    assign accept = in_ready_o & in_valid_i;
    assign pop    = out_valid_o & out_ready_i;
    assign last   = (cnt_q == CW'(N_COEFF - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (go) state_d = LOAD;
            LOAD:  state_d = FILL;
            FILL:  if (accept && last) state_d = KICK;
            KICK:  state_d = RUN;
            RUN: begin
                if (core_done_i) begin
                    state_d = READ;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR;
                end
            end
            READ:  state_d = DRAIN;
            DRAIN: if (pop && last) state_d = DONE;
            DONE:  state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Strobes are masked by abort so an aborted cycle never reaches the core.
    always_comb begin
        in_ready_o        = (state_q == FILL) & ~abort_i;
        core_load_a_f_o   = (state_q == LOAD) & ~op_inv_q & ~abort_i;
        core_load_a_i_o   = (state_q == LOAD) &  op_inv_q & ~abort_i;
        core_start_fntt_o = (state_q == KICK) & ~op_inv_q & ~abort_i;
        core_start_intt_o = (state_q == KICK) &  op_inv_q & ~abort_i;
        core_read_a_o     = (state_q == READ) & ~abort_i;
        core_read_en_o    = (state_q == DRAIN) & buf_can_push & ~abort_i;
        busy_o            = busy;
        done_o            = (state_q == DONE) & ~abort_i;
        err_o             = ((state_q == ERR) & ~abort_i) | bad_op_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            timer_q  <= '0;
            op_inv_q <= 1'b0;
            bad_op_q <= 1'b0;
            din_q    <= '0;
            din_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bad_op_q <= (state_q == IDLE) & start_i & ~op_valid(operation_i);
            din_en_q <= accept;
            if (accept) din_q <= in_data_i;
            if (go) op_inv_q <= (operation_i == INTT);

            if (abort || state_q == LOAD || state_q == READ) begin
                cnt_q <= '0;
            end else if (accept || (state_q == DRAIN && pop)) begin
                cnt_q <= cnt_q + CW'(1);
            end

            if (state_q == KICK) begin
                timer_q <= '0;
            end else if (state_q == RUN) begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    assign core_din_o    = din_q;
    assign core_din_en_o = din_en_q;
    assign cnt_o         = cnt_q;

    ntt_intt_out_buf #(
        .DATA_W(DATA_W)
    ) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .push     (core_gnt_valid_i & core_read_en_o),
        .push_data(core_dout_i),
        .pop_ready(out_ready_i),
        .can_push (buf_can_push),
        .out_valid(out_valid_o),
        .out_data (out_data_o)
    );

endmodule

// File: tb/tb_ntt_intt_ip_seq.sv
// Directed bench for the NTT/INTT sequencer with a behavioural core model.
// Results are checked against a scoreboard queue filled at input acceptance.
module tb_ntt_intt_ip_seq;
    import ntt_intt_ip_pkg::*;

    localparam int N  = 256;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_i, abort_i, in_valid_i, out_ready_i;
    logic [5:0]    operation_i;
    logic [DW-1:0] in_data_i;
    logic          in_ready_o;
    logic          core_load_a_f_o, core_load_a_i_o;
    logic          core_start_fntt_o, core_start_intt_o, core_read_a_o;
    logic [DW-1:0] core_din_o;
    logic          core_din_en_o;
    logic          core_done_i, core_gnt_valid_i, core_read_en_o;
    logic [DW-1:0] core_dout_i;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          busy_o, done_o, err_o;
    logic [8:0]    cnt_o;

    logic          start2;
    logic          in_ready2, load_f2, load_i2, start_f2, start_i2, read_a2;
    logic [DW-1:0] din2;
    logic          din_en2, read_en2, out_valid2;
    logic [DW-1:0] out_data2;
    logic          busy2, done2, err2;
    logic [3:0]    cnt2;
    logic          c2_done = 1'b0;
    logic          c2_gnt  = 1'b0;
    logic [DW-1:0] c2_dout = '0;

    ntt_intt_ip_seq dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .operation_i(operation_i), .abort_i(abort_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_ready_o(in_ready_o),
        .core_load_a_f_o(core_load_a_f_o),
        .core_load_a_i_o(core_load_a_i_o),
        .core_start_fntt_o(core_start_fntt_o),
        .core_start_intt_o(core_start_intt_o),
        .core_read_a_o(core_read_a_o),
        .core_din_o(core_din_o), .core_din_en_o(core_din_en_o),
        .core_done_i(core_done_i), .core_dout_i(core_dout_i),
        .core_gnt_valid_i(core_gnt_valid_i),
        .core_read_en_o(core_read_en_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_ready_i(out_ready_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .cnt_o(cnt_o)
    );

    ntt_intt_ip_seq #(.N_COEFF(8), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .rst_n(rst_n), .start_i(start2),
        .operation_i(operation_i), .abort_i(abort_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_ready_o(in_ready2),
        .core_load_a_f_o(load_f2), .core_load_a_i_o(load_i2),
        .core_start_fntt_o(start_f2), .core_start_intt_o(start_i2),
        .core_read_a_o(read_a2),
        .core_din_o(din2), .core_din_en_o(din_en2),
        .core_done_i(c2_done), .core_dout_i(c2_dout),
        .core_gnt_valid_i(c2_gnt), .core_read_en_o(read_en2),
        .out_valid_o(out_valid2), .out_data_o(out_data2),
        .out_ready_i(out_ready_i), .busy_o(busy2),
        .done_o(done2), .err_o(err2), .cnt_o(cnt2)
    );

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] xf(input logic [DW-1:0] w,
                                         input bit inv);
        return inv ? ~w : (w ^ 32'h5A5A_5A5A);
    endfunction

    logic [DW-1:0] sb[$];

    int n_load_f, n_load_i, n_start_f, n_start_i, n_read_a;
    int n_din_en, n_done, n_err, n_out;

    task automatic clr_counts();
        n_load_f = 0; n_load_i = 0; n_start_f = 0; n_start_i = 0;
        n_read_a = 0; n_din_en = 0; n_done = 0; n_err = 0; n_out = 0;
    endtask

    logic [DW-1:0] mem [N];
    int  cyc = 0;
    int  wr_idx = 0;
    int  rd_idx = 0;
    int  kick_cyc = 0;
    bit  running = 0;
    bit  streaming = 0;
    bit  inv_run = 0;
    bit  toggle = 0;

    // Core model and output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [4:0] s;
        s = {core_load_a_f_o, core_load_a_i_o, core_start_fntt_o,
             core_start_intt_o, core_read_a_o};
        if (|s) chk("strobe_onehot", 64'($onehot(s)), 64'd1);
        if (out_valid_o && !out_ready_i)
            chk("read_en_blocked", 64'(core_read_en_o), 64'd0);
        n_load_f  += int'(core_load_a_f_o);
        n_load_i  += int'(core_load_a_i_o);
        n_start_f += int'(core_start_fntt_o);
        n_start_i += int'(core_start_intt_o);
        n_read_a  += int'(core_read_a_o);
        n_din_en  += int'(core_din_en_o);
        n_done    += int'(done_o);
        n_err     += int'(err_o);
        if (core_load_a_f_o || core_load_a_i_o) wr_idx = 0;
        if (core_din_en_o) begin
            if (wr_idx < N) mem[wr_idx] = core_din_o;
            wr_idx++;
        end
        if (core_start_fntt_o || core_start_intt_o) begin
            running  = 1;
            inv_run  = core_start_intt_o;
            kick_cyc = cyc;
        end
        if (core_done_i) running = 0;
        if (core_read_a_o) begin
            streaming = 1;
            rd_idx    = 0;
        end
        if (core_gnt_valid_i && core_read_en_o) begin
            rd_idx++;
            if (rd_idx == N) streaming = 0;
        end
        if (out_valid_o && out_ready_i) begin
            n_out++;
            if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else chk("out_data", 64'(out_data_o), 64'(sb.pop_front()));
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        core_done_i      = running && (cyc == kick_cyc + 100);
        core_gnt_valid_i = streaming;
        core_dout_i      = streaming ? xf(mem[rd_idx], inv_run) : '0;
        out_ready_i      = toggle ? (cyc % 2 == 0) : 1'b1;
    end

    task automatic start_job(input bit sel, input logic [5:0] op);
        @(posedge clk); #1;
        if (sel) start2 = 1'b1;
        else     start_i = 1'b1;
        operation_i = op;
        @(posedge clk); #1;
        start_i = 1'b0;
        start2  = 1'b0;
    endtask

    task automatic fill(input int n, input bit sel, input bit push,
                        input bit inv, input int base);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 4 * n + 20) begin
            @(posedge clk); #1;
            in_valid_i = 1'b1;
            in_data_i  = DW'(base + i);
            @(negedge clk);
            guard++;
            if (sel ? in_ready2 : in_ready_o) begin
                if (!sel) chk("fill_cnt", 64'(cnt_o), 64'(i));
                if (push) sb.push_back(xf(DW'(base + i), inv));
                i++;
            end
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        chk("fill_complete", 64'(i), 64'(n));
    endtask

    task automatic wait_done(input int bound);
        int  t = 0;
        bit  got = 0;
        while (!got && t < bound) begin
            @(negedge clk);
            t++;
            if (done_o) got = 1;
        end
        chk("done_seen", 64'(got), 64'd1);
        @(negedge clk);
        chk("done_one_cycle", 64'(done_o), 64'd0);
        chk("busy_after_done", 64'(busy_o), 64'd0);
    endtask

    initial begin
        int k2, e2, t;
        rst_n = 1'b0;
        start_i = 0; start2 = 0; abort_i = 0; in_valid_i = 0;
        operation_i = '0; in_data_i = '0;
        core_done_i = 0; core_gnt_valid_i = 0; core_dout_i = '0;
        out_ready_i = 1'b1;
        clr_counts();
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd0);
        chk("rst_cnt", 64'(cnt_o), 64'd0);
        chk("rst_din_en", 64'(core_din_en_o), 64'd0);
        chk("rst_read_en", 64'(core_read_en_o), 64'd0);
        chk("rst_strobes", 64'({core_load_a_f_o, core_load_a_i_o,
            core_start_fntt_o, core_start_intt_o, core_read_a_o}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Forward job, full throughput.
        clr_counts();
        start_job(0, NTT);
        fill(N, 0, 1, 0, 0);
        wait_done(2000);
        chk("ntt_load_f", 64'(n_load_f), 64'd1);
        chk("ntt_load_i", 64'(n_load_i), 64'd0);
        chk("ntt_din_en", 64'(n_din_en), 64'(N));
        chk("ntt_start_f", 64'(n_start_f), 64'd1);
        chk("ntt_start_i", 64'(n_start_i), 64'd0);
        chk("ntt_read_a", 64'(n_read_a), 64'd1);
        chk("ntt_outputs", 64'(n_out), 64'(N));
        chk("ntt_sb_empty", 64'(sb.size()), 64'd0);
        chk("ntt_done_cnt", 64'(n_done), 64'd1);

        // Inverse job with a throttled consumer.
        clr_counts();
        toggle = 1;
        start_job(0, INTT);
        fill(N, 0, 1, 1, 1000);
        wait_done(3000);
        toggle = 0;
        chk("intt_load_i", 64'(n_load_i), 64'd1);
        chk("intt_load_f", 64'(n_load_f), 64'd0);
        chk("intt_start_i", 64'(n_start_i), 64'd1);
        chk("intt_start_f", 64'(n_start_f), 64'd0);
        chk("intt_din_en", 64'(n_din_en), 64'(N));
        chk("intt_outputs", 64'(n_out), 64'(N));
        chk("intt_sb_empty", 64'(sb.size()), 64'd0);

        // Illegal op code.
        clr_counts();
        start_job(0, 6'h3F);
        @(negedge clk);
        chk("badop_err", 64'(err_o), 64'd1);
        chk("badop_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        chk("badop_err_pulse", 64'(err_o), 64'd0);
        chk("badop_busy2", 64'(busy_o), 64'd0);
        chk("badop_strobes", 64'(n_load_f + n_load_i + n_start_f +
            n_start_i + n_read_a), 64'd0);
        chk("badop_err_cnt", 64'(n_err), 64'd1);

        // Run timeout on the short-timeout instance.
        start_job(1, NTT);
        fill(8, 1, 0, 0, 50);
        k2 = -1; e2 = -1; t = 0;
        while (e2 < 0 && t < 200) begin
            @(negedge clk);
            t++;
            if (start_f2) k2 = cyc;
            if (err2) e2 = cyc;
        end
        chk("to_kick_seen", 64'(k2 >= 0), 64'd1);
        chk("to_err_delay", 64'(e2 - (k2 + 1)), 64'd16);
        @(negedge clk);
        chk("to_err_pulse", 64'(err2), 64'd0);
        chk("to_idle", 64'(busy2), 64'd0);

        // Abort partway through fill.
        clr_counts();
        start_job(0, NTT);
        fill(100, 0, 0, 0, 7);
        @(posedge clk); #1;
        abort_i = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready_o), 64'd0);
        @(posedge clk); #1;
        abort_i = 1'b0;
        @(negedge clk);
        chk("abort_idle", 64'(busy_o), 64'd0);
        chk("abort_cnt", 64'(cnt_o), 64'd0);
        chk("abort_out_valid", 64'(out_valid_o), 64'd0);
        repeat (5) @(negedge clk);
        chk("abort_no_start", 64'(n_start_f + n_start_i), 64'd0);
        chk("abort_din_en", 64'(n_din_en), 64'd100);
        chk("abort_no_pulse", 64'(n_done + n_err), 64'd0);

        // Follow-up job; a stray start during RUN must be ignored.
        clr_counts();
        start_job(0, NTT);
        fill(N, 0, 1, 0, 3000);
        repeat (20) @(posedge clk);
        #1;
        start_i = 1'b1;
        operation_i = INTT;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(2000);
        repeat (3) @(negedge clk);
        chk("rerun_done_cnt", 64'(n_done), 64'd1);
        chk("rerun_start_f", 64'(n_start_f), 64'd1);
        chk("rerun_start_i", 64'(n_start_i), 64'd0);
        chk("rerun_load_i", 64'(n_load_i), 64'd0);
        chk("rerun_outputs", 64'(n_out), 64'(N));
        chk("rerun_sb_empty", 64'(sb.size()), 64'd0);
        chk("rerun_idle", 64'(busy_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
